// File: rtl/hwtimer_mc.sv
// Purpose : multi-channel timer; per-channel prescaler, counter, compare, pending bit and irq.
// Latency : writes commit on the sampling edge; read data appears on data_o one cycle later.
// Backpr. : none; the bus is never stalled and every request completes without wait states.
//
// Ports   : clk_i/rst_i (async active-low) clock and reset; req_i/we_i/addr_i/data_i bus
//           request; data_o registered read data; irq_vec_o per-channel irq; irq_o OR of all.
// Map     : channel n at n*0x10 (+0 CTRL, +4 PRESCALE, +8 COMPARE, +C COUNT); 0x100 STATUS
//           (W1C); 0x104 ENABLE_ALL. CTRL = {CASCADE, IE, PERIODIC, EN}.
// Option  : define HWTIMER_CASCADE_EN to let channel n>0 tick on channel n-1's match event.
module hwtimer_mc #(
   parameter int NrChannels = 4,
   parameter int CntWidth   = 32,
   parameter int PscWidth   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [31:0]           addr_i,
   input  logic [31:0]           data_i,
   output logic [31:0]           data_o,
   output logic [NrChannels-1:0] irq_vec_o,
   output logic                  irq_o
);

   localparam int N = NrChannels;

   logic [N-1:0]          en, per, ie, cas, status;
   logic [PscWidth-1:0]   psc [N];
   logic [PscWidth-1:0]   psc_cnt [N];
   logic [CntWidth-1:0]   cmp [N];
   logic [CntWidth-1:0]   cnt [N];

   logic                  wr, rd, glb, wr_status, wr_enall;
   logic [3:0]            ch_sel;
   logic [1:0]            reg_sel;
   logic [N-1:0]          wr_ctrl, wr_psc, wr_cmp, wr_cnt, en_clr, tick, match;
   logic [31:0]           rdata;
   logic                  unused_addr;

   assign wr          = req_i & we_i;
   assign rd          = req_i & ~we_i;
   assign glb         = addr_i[8];
   assign ch_sel      = addr_i[7:4];
   assign reg_sel     = addr_i[3:2];
   assign wr_status   = wr & glb & (addr_i[7:2] == 6'd0);
   assign wr_enall    = wr & glb & (addr_i[7:2] == 6'd1);
   assign unused_addr = ^{addr_i[31:9], addr_i[1:0]};

   // Channel strobes; indices >= N never match, so those writes fall on the floor.
   always_comb begin
      wr_ctrl = '0;
      wr_psc  = '0;
      wr_cmp  = '0;
      wr_cnt  = '0;
      en_clr  = '0;
      for (int n = 0; n < N; n++) begin
         if (wr && !glb && ch_sel == 4'(n)) begin
            wr_ctrl[n] = (reg_sel == 2'd0);
            wr_psc[n]  = (reg_sel == 2'd1);
            wr_cmp[n]  = (reg_sel == 2'd2);
            wr_cnt[n]  = (reg_sel == 2'd3);
         end
         // Any software write that drops EN this cycle freezes COUNT on this edge.
         en_clr[n] = (wr_ctrl[n] & ~data_i[0]) | (wr_enall & ~data_i[n]);
      end
   end

   // Tick/match chain: a cascaded channel sees the previous channel's match in the same cycle.
   always_comb begin : tick_chain
      logic chain;
      chain = 1'b0;
      tick  = '0;
      match = '0;
      for (int n = 0; n < N; n++) begin
         if (cas[n]) tick[n] = en[n] & chain;
         else        tick[n] = en[n] & (psc_cnt[n] == psc[n]);
         match[n] = tick[n] & (cnt[n] == cmp[n]);
         chain    = match[n];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         en     <= '0;
         per    <= '0;
         ie     <= '0;
         status <= '0;
         for (int n = 0; n < N; n++) begin
            psc[n]     <= '0;
            psc_cnt[n] <= '0;
            cmp[n]     <= '1;
            cnt[n]     <= '0;
         end
      end else begin
         for (int n = 0; n < N; n++) begin
            // Software writes win over the one-shot auto-disable.
            if (wr_ctrl[n]) begin
               en[n]  <= data_i[0];
               per[n] <= data_i[1];
               ie[n]  <= data_i[2];
            end else if (wr_enall) begin
               en[n] <= data_i[n];
            end else if (match[n] && !per[n]) begin
               en[n] <= 1'b0;
            end

            if (wr_psc[n]) psc[n] <= data_i[PscWidth-1:0];
            if (wr_cmp[n]) cmp[n] <= data_i[CntWidth-1:0];

            if (wr_cnt[n])
               cnt[n] <= data_i[CntWidth-1:0];
            else if (tick[n] && !en_clr[n])
               cnt[n] <= match[n] ? '0 : cnt[n] + CntWidth'(1);

            // Held at 0 while disabled (or cascaded) so enabling starts a full period.
            if (!en[n] || cas[n] || psc_cnt[n] == psc[n])
               psc_cnt[n] <= '0;
            else
               psc_cnt[n] <= psc_cnt[n] + PscWidth'(1);
         end
         // OR-ing match after the clear makes a same-cycle hardware set win.
         status <= (status & ~({N{wr_status}} & data_i[N-1:0])) | match;
      end
   end

`ifdef HWTIMER_CASCADE_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cas <= '0;
      end else begin
         // Channel 0 has no predecessor, so its CASCADE bit stays 0.
         for (int n = 1; n < N; n++) begin
            if (wr_ctrl[n]) cas[n] <= data_i[3];
         end
      end
   end
`else
   assign cas = '0;
`endif

   always_comb begin
      rdata = '0;
      if (glb) begin
         if (addr_i[7:2] == 6'd0)      rdata = 32'(status);
         else if (addr_i[7:2] == 6'd1) rdata = 32'(en);
      end else begin
         for (int n = 0; n < N; n++) begin
            if (ch_sel == 4'(n)) begin
               case (reg_sel)
                  2'd0:    rdata = {28'd0, cas[n], ie[n], per[n], en[n]};
                  2'd1:    rdata = 32'(psc[n]);
                  2'd2:    rdata = 32'(cmp[n]);
                  default: rdata = 32'(cnt[n]);
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)  data_o <= '0;
      else if (rd) data_o <= rdata;
   end

   assign irq_vec_o = status & ie;
   assign irq_o     = |irq_vec_o;

endmodule

// File: tb/tb_hwtimer_mc.sv
// Bench for hwtimer_mc: directed scenarios plus randomized timer configurations whose
// interrupt times are predicted arithmetically: first match after (PRESCALE+1)*(ticks) cycles
// where ticks = (COMPARE-COUNT mod 2^32)+1, then every (PRESCALE+1)*(COMPARE+1) cycles.
module tb_hwtimer_mc;

   localparam int N = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [31:0]   addr_i = '0;
   logic [31:0]   data_i = '0;
   logic [31:0]   data_o;
   logic [N-1:0]  irq_vec_o;
   logic          irq_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   hwtimer_mc #(.NrChannels(N), .CntWidth(32), .PscWidth(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .data_i(data_i), .data_o(data_o), .irq_vec_o(irq_vec_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Returns the index of the edge at which the write was sampled.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int commit);
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
      @(negedge clk_i);
      commit = cyc;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      int c;
      bus_write(a, d, c);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      @(negedge clk_i);
      req_i = 1'b0;
      d = data_o;
   endtask

   // Edge index at which irq_vec_o[ch] is first seen high, or -1 if the budget runs out.
   task automatic wait_irq(input int ch, input int bound, output int at);
      at = -1;
      for (int k = 0; k < bound; k++) begin
         if (irq_vec_o[ch]) begin
            at = cyc;
            break;
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset();
      logic [31:0] r, e;
      total++; if (data_o !== 32'd0) begin bad++; $display("FAIL reset_data_o got %h want 0", data_o); end
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq_o); end
      total++; if (irq_vec_o !== '0) begin bad++; $display("FAIL reset_irq_vec got %b want 0", irq_vec_o); end
      for (int ch = 0; ch <= N; ch++) begin
         for (int rg = 0; rg < 4; rg++) begin
            bus_read(32'(ch * 16 + rg * 4), r);
            e = (ch < N && rg == 2) ? 32'hFFFF_FFFF : 32'd0;
            total++;
            if (r !== e) begin bad++; $display("FAIL reset_reg ch=%0d reg=%0d got %h want %h", ch, rg, r, e); end
         end
      end
      bus_read(32'h100, r);
      total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_status got %h want 0", r); end
      bus_read(32'h200, r);
      total++; if (r !== 32'd0) begin bad++; $display("FAIL reset_0x200 got %h want 0", r); end
   endtask

   task automatic test_enable_all();
      logic [31:0] r;
      bus_wr(32'h104, 32'h5);
      bus_read(32'h000, r);
      total++; if (r !== 32'h1) begin bad++; $display("FAIL enall_ctrl0 got %h want 1", r); end
      bus_read(32'h010, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL enall_ctrl1 got %h want 0", r); end
      bus_read(32'h020, r);
      total++; if (r !== 32'h1) begin bad++; $display("FAIL enall_ctrl2 got %h want 1", r); end
      bus_wr(32'h104, 32'h0);
      total++; if (data_o !== 32'h1) begin bad++; $display("FAIL data_o_hold got %h want 1", data_o); end
      bus_read(32'h020, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL enall_off got %h want 0", r); end
      bus_wr(32'h040, 32'h7);
      bus_read(32'h040, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL unmapped_ch got %h want 0", r); end
      bus_wr(32'h108, 32'hFFFF_FFFF);
      bus_read(32'h108, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL unmapped_glb got %h want 0", r); end
      bus_wr(32'h000, 32'hFFFF_FFF0);
      bus_read(32'h000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL ctrl_mask got %h want 0", r); end
   endtask

   task automatic test_periodic();
      logic [31:0] r;
      int c0, at;
      bus_wr(32'h004, 32'd3);
      bus_wr(32'h008, 32'd4);
      bus_wr(32'h00C, 32'd0);
      bus_write(32'h000, 32'h7, c0);
      wait_irq(0, 40, at);
      total++; if (at !== c0 + 20) begin bad++; $display("FAIL periodic_first got %0d want %0d", at - c0, 20); end
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL periodic_irq got %b want 1", irq_o); end
      bus_read(32'h00C, r);
      total++; if (r !== 32'd0) begin bad++; $display("FAIL periodic_count got %h want 0", r); end
      bus_wr(32'h100, 32'h1);
      total++; if (irq_vec_o[0] !== 1'b0) begin bad++; $display("FAIL w1c got %b want 0", irq_vec_o[0]); end
      wait_irq(0, 40, at);
      total++; if (at !== c0 + 40) begin bad++; $display("FAIL periodic_second got %0d want %0d", at - c0, 40); end
      bus_wr(32'h100, 32'h1);
      while (cyc < c0 + 59) @(negedge clk_i);
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL pre_collide got %b want 0", irq_o); end
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h100; data_i = 32'h1;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0;
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL collide_irq got %b want 1", irq_o); end
      @(negedge clk_i);
      bus_read(32'h100, r);
      total++; if (r !== 32'h1) begin bad++; $display("FAIL collide_status got %h want 1", r); end
      bus_wr(32'h000, 32'h0);
      bus_wr(32'h100, 32'hF);
   endtask

   task automatic test_oneshot();
      logic [31:0] r;
      int c0, at;
      bus_wr(32'h014, 32'd0);
      bus_wr(32'h018, 32'd2);
      bus_wr(32'h01C, 32'd0);
      bus_write(32'h010, 32'h5, c0);
      wait_irq(1, 20, at);
      total++; if (at !== c0 + 3) begin bad++; $display("FAIL oneshot_time got %0d want 3", at - c0); end
      bus_read(32'h010, r);
      total++; if (r !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl got %h want 4", r); end
      repeat (5) @(negedge clk_i);
      bus_read(32'h01C, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL oneshot_count got %h want 0", r); end
      bus_read(32'h100, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL oneshot_status got %h want 2", r); end
      bus_wr(32'h100, 32'h2);
      // Pending without IE must not interrupt until IE is set.
      bus_wr(32'h034, 32'd0);
      bus_wr(32'h038, 32'd0);
      bus_wr(32'h03C, 32'd0);
      bus_wr(32'h030, 32'h1);
      repeat (3) @(negedge clk_i);
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ie_off_irq got %b want 0", irq_o); end
      bus_read(32'h100, r);
      total++; if (r !== 32'h8) begin bad++; $display("FAIL ie_off_status got %h want 8", r); end
      bus_wr(32'h030, 32'h4);
      total++; if (irq_vec_o !== 4'b1000) begin bad++; $display("FAIL ie_on_vec got %b want 1000", irq_vec_o); end
      bus_wr(32'h100, 32'h8);
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ie_clear got %b want 0", irq_o); end
      bus_wr(32'h030, 32'h0);
   endtask

   task automatic test_wrap();
      int c0, at;
      bus_wr(32'h024, 32'd0);
      bus_wr(32'h028, 32'd5);
      bus_wr(32'h02C, 32'hFFFF_FFF0);
      bus_write(32'h020, 32'h5, c0);
      wait_irq(2, 40, at);
      total++; if (at !== c0 + 22) begin bad++; $display("FAIL wrap_time got %0d want 22", at - c0); end
      bus_wr(32'h020, 32'h0);
      bus_wr(32'h100, 32'h4);
   endtask

   task automatic test_ctrl_race();
      logic [31:0] r;
      int c0;
      bus_wr(32'h024, 32'd0);
      bus_wr(32'h028, 32'd4);
      bus_wr(32'h02C, 32'd0);
      bus_write(32'h020, 32'h3, c0);
      while (cyc < c0 + 4) @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h020; data_i = 32'h0;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0;
      bus_read(32'h02C, r);
      total++; if (r !== 32'd4) begin bad++; $display("FAIL race_count got %h want 4", r); end
      bus_read(32'h100, r);
      total++; if (r !== 32'h4) begin bad++; $display("FAIL race_status got %h want 4", r); end
      bus_read(32'h020, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL race_ctrl got %h want 0", r); end
      bus_wr(32'h100, 32'h4);
   endtask

   task automatic test_count_write();
      logic [31:0] r, e;
      int c0, w, w2;
      bus_wr(32'h014, 32'd0);
      bus_wr(32'h018, 32'd1000);
      bus_wr(32'h01C, 32'd0);
      bus_write(32'h010, 32'h1, c0);
      bus_write(32'h01C, 32'd100, w);
      bus_write(32'h010, 32'h0, w2);
      e = 32'(100 + (w2 - w - 1));
      bus_read(32'h01C, r);
      total++; if (r !== e) begin bad++; $display("FAIL count_write got %h want %h", r, e); end
   endtask

   task automatic test_cascade();
      logic [31:0] r;
      bus_wr(32'h000, 32'h8);
      bus_read(32'h000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL cas_ch0 got %h want 0", r); end
      bus_wr(32'h000, 32'h0);
`ifdef HWTIMER_CASCADE_EN
      begin
         int c0, at;
         bus_wr(32'h018, 32'd2);
         bus_wr(32'h01C, 32'd0);
         bus_wr(32'h010, 32'hF);
         bus_wr(32'h004, 32'd0);
         bus_wr(32'h008, 32'd1);
         bus_wr(32'h00C, 32'd0);
         bus_write(32'h000, 32'h3, c0);
         wait_irq(1, 30, at);
         total++; if (at !== c0 + 6) begin bad++; $display("FAIL cascade_first got %0d want 6", at - c0); end
         bus_wr(32'h100, 32'h2);
         wait_irq(1, 30, at);
         total++; if (at !== c0 + 12) begin bad++; $display("FAIL cascade_second got %0d want 12", at - c0); end
         bus_wr(32'h000, 32'h0);
         bus_wr(32'h010, 32'h0);
         bus_wr(32'h100, 32'hF);
      end
`else
      bus_wr(32'h010, 32'h8);
      bus_read(32'h010, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL cas_ch1 got %h want 0", r); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] r, base;
      int ch, p, c, d, pr, c0, at, first;
      for (int it = 0; it < 8; it++) begin
         ch   = $urandom_range(0, N - 1);
         p    = $urandom_range(0, 5);
         c    = $urandom_range(1, 12);
         d    = $urandom_range(0, c);
         pr   = $urandom_range(0, 1);
         base = 32'(ch * 16);
         bus_wr(base + 32'h4, 32'(p));
         bus_wr(base + 32'h8, 32'(c));
         bus_wr(base + 32'hC, 32'(c - d));
         bus_write(base, 32'(5 + 2 * pr), c0);
         first = c0 + (p + 1) * (d + 1);
         wait_irq(ch, (p + 1) * (d + 1) + 20, at);
         total++; if (at !== first) begin bad++; $display("FAIL rand_first it=%0d got %0d want %0d", it, at - c0, first - c0); end
         if (pr == 1) begin
            bus_wr(32'h100, 32'(1 << ch));
            wait_irq(ch, (p + 1) * (c + 1) + 20, at);
            total++; if (at !== first + (p + 1) * (c + 1)) begin bad++; $display("FAIL rand_period it=%0d got %0d want %0d", it, at - first, (p + 1) * (c + 1)); end
         end else begin
            bus_read(base, r);
            total++; if (r !== 32'h4) begin bad++; $display("FAIL rand_oneshot_ctrl it=%0d got %h want 4", it, r); end
            bus_read(base + 32'hC, r);
            total++; if (r !== 32'h0) begin bad++; $display("FAIL rand_oneshot_count it=%0d got %h want 0", it, r); end
         end
         bus_wr(base, 32'h0);
         bus_wr(32'h100, 32'hF);
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] r;
      int at;
      bus_wr(32'h004, 32'd3);
      bus_wr(32'h008, 32'd4);
      bus_wr(32'h00C, 32'd0);
      bus_wr(32'h000, 32'h7);
      bus_wr(32'h014, 32'd0);
      bus_wr(32'h018, 32'd0);
      bus_wr(32'h01C, 32'd0);
      bus_wr(32'h010, 32'h5);
      bus_read(32'h008, r);
      repeat (2) @(negedge clk_i);
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got %b want 1", irq_o); end
      #2 rst_i = 1'b0;
      #1;
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL async_reset_irq got %b want 0", irq_o); end
      total++; if (data_o !== 32'd0) begin bad++; $display("FAIL async_reset_data got %h want 0", data_o); end
      @(negedge clk_i);
      rst_i = 1'b1;
      bus_read(32'h000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_ctrl got %h want 0", r); end
      bus_read(32'h004, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_psc got %h want 0", r); end
      bus_read(32'h008, r);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_cmp got %h want ffffffff", r); end
      bus_read(32'h00C, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_count got %h want 0", r); end
      bus_read(32'h100, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_status got %h want 0", r); end
      bus_read(32'h200, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_0x200 got %h want 0", r); end
      wait_irq(0, 30, at);
      total++; if (at !== -1) begin bad++; $display("FAIL mid_no_irq got %0d want -1", at); end
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      test_reset();
      test_enable_all();
      test_periodic();
      test_oneshot();
      test_wrap();
      test_ctrl_race();
      test_count_write();
      test_cascade();
      test_random();
      test_reset_midcount();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
